// File: rtl/key_debounce.sv
// key_debounce: conditions raw pushbuttons for the key PIO.
// Each key passes through a 2-flop synchronizer and a counter debouncer.
// The debouncer drives press/release strobes and a sticky press latch.
// key_out keeps the raw key polarity, so the PIO sees the board encoding.
module key_debounce #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic [N_KEYS-1:0] event_clear,
  output logic [N_KEYS-1:0] key_out,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] event_pending
);

  // Released level of a key; the pressed level is its complement.
  localparam logic              REL      = ACTIVE_LOW;
  localparam logic [N_KEYS-1:0] REL_VEC  = {N_KEYS{REL}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [N_KEYS-1:0]            sync1_q;
  logic [N_KEYS-1:0]            sync2_q;
  logic [N_KEYS-1:0]            key_q;
  logic [N_KEYS-1:0]            key_d;
  logic [N_KEYS-1:0]            press_q;
  logic [N_KEYS-1:0]            press_d;
  logic [N_KEYS-1:0]            release_q;
  logic [N_KEYS-1:0]            release_d;
  logic [N_KEYS-1:0]            pending_q;
  logic [N_KEYS-1:0]            pending_d;
  logic [N_KEYS-1:0][CNT_W-1:0] cnt_q;
  logic [N_KEYS-1:0][CNT_W-1:0] cnt_d;

  // Two-flop synchronizer; it resets to the released level, so a key held through reset counts as a fresh press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= REL_VEC;
      sync2_q <= REL_VEC;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce each key: a differing level must persist for DEBOUNCE_CYCLES edges, and any reversion restarts the count.
  always_comb begin
    key_d     = key_q;
    cnt_d     = cnt_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (sync2_q[i] == key_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i] = '0;
        key_d[i] = sync2_q[i];
        if (sync2_q[i] == REL) begin
          release_d[i] = 1'b1;
        end else begin
          press_d[i] = 1'b1;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    // A press arriving on the same edge as a clear wins.
    pending_d = (pending_q & ~event_clear) | press_d;
  end

  // Debounced level, counters, strobes and the press latch; every output is a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q     <= REL_VEC;
      cnt_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      pending_q <= '0;
    end else begin
      key_q     <= key_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      pending_q <= pending_d;
    end
  end

  assign key_out       = key_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign event_pending = pending_q;

endmodule

// File: tb/tb_key_debounce.sv
// Testbench for key_debounce with DEBOUNCE_CYCLES=4, two active-low keys.
// Directed scenarios check fixed expectations.
// A random run checks against a window-based reference model.
module tb_key_debounce;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] key_raw;
  logic [1:0] event_clear;
  logic [1:0] key_out;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;
  logic [1:0] event_pending;

  int checks   = 0;
  int failures = 0;

  // Reference model: an ideal delay line, plus a window of the last D synchronized samples per key.
  logic [1:0]   m_s1, m_s2, m_out, m_press, m_rel, m_pend;
  logic [D-1:0] m_win [2];
  int           m_len [2];

  key_debounce #(
    .N_KEYS(2), .DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_raw(key_raw), .event_clear(event_clear),
    .key_out(key_out), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .event_pending(event_pending)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1 = 2'b11; m_s2 = 2'b11; m_out = 2'b11;
    m_press = 2'b00; m_rel = 2'b00; m_pend = 2'b00;
    for (int k = 0; k < 2; k++) begin
      m_win[k] = '0;
      m_len[k] = 0;
    end
  endtask

  // A key flips once the last D samples all disagree with its current level, with no flip inside that window.
  task automatic model_step();
    if (!reset_n) begin
      model_reset();
    end else begin
      m_press = 2'b00;
      m_rel   = 2'b00;
      for (int k = 0; k < 2; k++) begin
        m_win[k] = {m_win[k][D-2:0], m_s2[k]};
        if (m_len[k] < D) m_len[k]++;
        if (m_len[k] == D && m_win[k] == {D{~m_out[k]}}) begin
          m_out[k] = ~m_out[k];
          m_len[k] = 0;
          if (m_out[k]) m_rel[k] = 1'b1;
          else          m_press[k] = 1'b1;
        end
      end
      m_pend = (m_pend & ~event_clear) | m_press;
      m_s2 = m_s1;
      m_s1 = key_raw;
    end
  endtask

  // One clock edge: the model steps on the edge, and control returns on the following negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    key_raw = 2'b11;
    event_clear = 2'b00;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    key_raw = 2'b00;
    event_clear = 2'b11;
    repeat (3) @(negedge clk);
    checks++;
    if ({key_out, press_pulse, release_pulse, event_pending} !== 8'b11_00_00_00) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", {key_out, press_pulse, release_pulse, event_pending}, 8'b11_00_00_00);
    end
    do_reset();
  endtask

  task automatic test_clean_press();
    do_reset();
    key_raw = 2'b10;
    for (int e = 0; e <= 6; e++) begin
      tick();
      checks++;
      if (key_out !== ((e >= 5) ? 2'b10 : 2'b11)) begin
        failures++;
        $display("FAIL clean_key_out edge=%0d got=%b exp=%b", e, key_out, (e >= 5) ? 2'b10 : 2'b11);
      end
      checks++;
      if (press_pulse !== ((e == 5) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL clean_press edge=%0d got=%b exp=%b", e, press_pulse, (e == 5) ? 2'b01 : 2'b00);
      end
      checks++;
      if (event_pending[0] !== (e >= 5)) begin
        failures++;
        $display("FAIL clean_pending edge=%0d got=%b exp=%b", e, event_pending[0], e >= 5);
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    int presses;
    pat = 8'b11001100;
    presses = 0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      key_raw[0] = (i < 8) ? pat[i] : 1'b0;
      tick();
      if (press_pulse[0]) presses++;
      checks++;
      if (key_out[0] !== ((i >= 13) ? 1'b0 : 1'b1)) begin
        failures++;
        $display("FAIL bounce_key_out step=%0d got=%b exp=%b", i, key_out[0], (i >= 13) ? 1'b0 : 1'b1);
      end
    end
    checks++;
    if (presses != 1) begin
      failures++;
      $display("FAIL bounce_press_count got=%0d exp=1", presses);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      key_raw[1] = (i < 3) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if ({key_out, press_pulse, release_pulse, event_pending[1]} !== 7'b11_00_00_0) begin
        failures++;
        $display("FAIL glitch step=%0d got=%b exp=%b", i, {key_out, press_pulse, release_pulse, event_pending[1]}, 7'b11_00_00_0);
      end
    end
  endtask

  task automatic test_release_clear();
    do_reset();
    key_raw = 2'b10;
    repeat (6) tick();
    checks++;
    if (key_out !== 2'b10) begin
      failures++;
      $display("FAIL rel_pressed got=%b exp=10", key_out);
    end
    key_raw = 2'b11;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if ({key_out, release_pulse, event_pending[0]} !== {((i >= 5) ? 2'b11 : 2'b10), ((i == 5) ? 2'b01 : 2'b00), 1'b1}) begin
        failures++;
        $display("FAIL release step=%0d got=%b exp=%b", i, {key_out, release_pulse, event_pending[0]},
                 {((i >= 5) ? 2'b11 : 2'b10), ((i == 5) ? 2'b01 : 2'b00), 1'b1});
      end
    end
    event_clear = 2'b01;
    tick();
    event_clear = 2'b00;
    checks++;
    if (event_pending[0] !== 1'b0) begin
      failures++;
      $display("FAIL clear_edge got=%b exp=0", event_pending[0]);
    end
    tick();
    checks++;
    if (event_pending !== 2'b00) begin
      failures++;
      $display("FAIL clear_hold got=%b exp=00", event_pending);
    end
  endtask

  task automatic test_collision();
    do_reset();
    key_raw = 2'b01;
    repeat (5) tick();
    event_clear = 2'b10;
    tick();
    event_clear = 2'b00;
    checks++;
    if ({press_pulse, event_pending[1]} !== 3'b10_1) begin
      failures++;
      $display("FAIL collision got=%b exp=101", {press_pulse, event_pending[1]});
    end
    tick();
    checks++;
    if ({press_pulse, event_pending[1]} !== 3'b00_1) begin
      failures++;
      $display("FAIL collision_after got=%b exp=001", {press_pulse, event_pending[1]});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    key_raw = 2'b10;
    repeat (6) tick();
    key_raw = 2'b00;
    repeat (4) tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({key_out, press_pulse, release_pulse, event_pending} !== 8'b11_00_00_00) begin
      failures++;
      $display("FAIL midreset_async got=%b exp=%b", {key_out, press_pulse, release_pulse, event_pending}, 8'b11_00_00_00);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if ({key_out, press_pulse} !== {((i >= 5) ? 2'b00 : 2'b11), ((i == 5) ? 2'b11 : 2'b00)}) begin
        failures++;
        $display("FAIL midreset_redetect step=%0d got=%b exp=%b", i, {key_out, press_pulse},
                 {((i >= 5) ? 2'b00 : 2'b11), ((i == 5) ? 2'b11 : 2'b00)});
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] lvl;
    int rem [2];
    lvl = 2'b11;
    rem[0] = 0;
    rem[1] = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (rem[k] == 0) begin
          lvl[k] = 1'($urandom_range(0, 1));
          rem[k] = $urandom_range(1, 8);
        end
        rem[k]--;
        event_clear[k] = ($urandom_range(0, 7) == 0);
      end
      key_raw = lvl;
      tick();
      checks++;
      if ({key_out, press_pulse, release_pulse, event_pending} !== {m_out, m_press, m_rel, m_pend}) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", c, {key_out, press_pulse, release_pulse, event_pending},
                 {m_out, m_press, m_rel, m_pend});
      end
    end
    event_clear = 2'b00;
  endtask

  initial begin
    reset_n = 1'b0;
    key_raw = 2'b11;
    event_clear = 2'b00;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_release_clear();
    test_collision();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
